zeroriscy_mem_slave: RTL and testbench

Parametrised memory responder for the zero-riscy instruction and data ports, implementing the req/gnt/rvalid protocol with configurable grant stall, fixed response latency and a bound on outstanding transactions. It replaces hand-driven gnt/rvalid stimulus in core-level benches: one instance sits on the instr_* port, one on the data_* port. It holds a word array with byte-enable writes, range/alignment error responses and a backdoor preload port.

---
 rtl/zeroriscy_mem_pkg.sv | 30 +++
 rtl/zeroriscy_mem_resp_pipe.sv | 55 +++++
 rtl/zeroriscy_mem_slave.sv | 170 +++++++++++++++++
 tb/tb_zeroriscy_mem_slave.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroriscy_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zeroriscy_mem_pkg                                            |
// | Description : Shared types and helpers for the zero-riscy memory responder.|
// |               resp_t is the {err, rdata} response record at the default    |
// |               word width. addr_in_range checks a byte address against a    |
// |               base and a byte size.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package zeroriscy_mem_pkg;

   localparam int unsigned DATA_WIDTH = 32;

   typedef struct packed {
      logic                  err;
      logic [DATA_WIDTH-1:0] rdata;
   } resp_t;

   // The comparison is done at 64 bits so that base + size cannot wrap
   // for any address width up to 32 bits.
   function automatic logic addr_in_range(
      input logic [63:0] addr,
      input logic [63:0] base,
      input logic [63:0] size_bytes
   );
      return (addr >= base) && (addr < (base + size_bytes));
   endfunction

endpackage
`default_nettype wire

// File: rtl/zeroriscy_mem_resp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zeroriscy_mem_resp_pipe                                      |
// | Description : Fixed-latency valid/payload delay line. Only the valid bits  |
// |               are reset, so a reset drops every response in flight.        |
// | Ports       : clk_i   - clock                                              |
// |               rst_ni  - asynchronous active-low reset                      |
// |               i_valid - response entering the line                         |
// |               i_data  - response payload                                   |
// |               o_valid - response leaving the line STAGES cycles later      |
// |               o_data  - payload of the leaving response                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module zeroriscy_mem_resp_pipe
   import zeroriscy_mem_pkg::*;
#(
   parameter int unsigned STAGES = 1,
   parameter int unsigned WIDTH  = 33
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic [STAGES-1:0] r_valid;
   logic [WIDTH-1:0]  r_data [STAGES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= i_valid;
         for (int s = 1; s < STAGES; s++) begin
            r_valid[s] <= r_valid[s-1];
         end
      end
   end

   // The payload carries no reset: it is only looked at while its valid
   // bit is set, and the top gates it to zero otherwise.
   always_ff @(posedge clk_i) begin
      r_data[0] <= i_data;
      for (int s = 1; s < STAGES; s++) begin
         r_data[s] <= r_data[s-1];
      end
   end

   assign o_valid = r_valid[STAGES-1];
   assign o_data  = r_data[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/zeroriscy_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zeroriscy_mem_slave                                          |
// | Description : req/gnt/rvalid memory responder for the zero-riscy           |
// |               instruction or data port. It has a word array with           |
// |               byte-enable writes, range and alignment error responses, a   |
// |               grant stall, a fixed response latency, a bound on            |
// |               outstanding transactions and a backdoor preload port.        |
// | Ports       : clk_i, rst_ni              - clock, async active-low reset   |
// |               req_i, gnt_o               - request / grant handshake       |
// |               we_i, be_i, addr_i, wdata_i - request fields                 |
// |               rvalid_o, rdata_o, err_o   - response                        |
// |               load_en_i, load_idx_i, load_data_i - backdoor word write     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module zeroriscy_mem_slave
   import zeroriscy_mem_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH      = 32,
   parameter int unsigned           DATA_WIDTH      = 32,
   parameter int unsigned           DEPTH_WORDS     = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int unsigned           GNT_STALL       = 0,
   parameter int unsigned           RVALID_LAT      = 1,
   parameter int unsigned           MAX_OUTSTANDING = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           req_i,
   output logic                           gnt_o,
   input  logic                           we_i,
   input  logic [DATA_WIDTH/8-1:0]        be_i,
   input  logic [ADDR_WIDTH-1:0]          addr_i,
   input  logic [DATA_WIDTH-1:0]          wdata_i,
   output logic                           rvalid_o,
   output logic [DATA_WIDTH-1:0]          rdata_o,
   output logic                           err_o,
   input  logic                           load_en_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx_i,
   input  logic [DATA_WIDTH-1:0]          load_data_i
);

   localparam int unsigned c_be_w    = DATA_WIDTH / 8;
   localparam int unsigned c_offs_w  = $clog2(c_be_w);
   localparam int unsigned c_idx_w   = $clog2(DEPTH_WORDS);
   localparam int unsigned c_out_w   = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned c_stall_w = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;

   localparam logic [63:0]           c_size_bytes = 64'(DEPTH_WORDS) * 64'(c_be_w);
   localparam logic [c_out_w-1:0]    c_max_out    = c_out_w'(MAX_OUTSTANDING);
   localparam logic [c_stall_w-1:0]  c_stall_max  = c_stall_w'(GNT_STALL);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
   logic [c_stall_w-1:0]  r_stall_cnt;
   logic [c_out_w-1:0]    r_outstanding;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic                  w_misaligned;
   logic                  w_in_range;
   logic                  w_dec_err;
   logic [ADDR_WIDTH-1:0] w_offset;
   logic [c_idx_w-1:0]    w_idx;
   logic [DATA_WIDTH-1:0] w_rd_word;

   generate
      if (c_offs_w > 0) begin : g_align_check
         assign w_misaligned = |addr_i[c_offs_w-1:0];
      end else begin : g_align_none
         assign w_misaligned = 1'b0;
      end
   endgenerate

   assign w_in_range = addr_in_range(64'(addr_i), 64'(BASE_ADDR), c_size_bytes);
   assign w_dec_err  = ~w_in_range | w_misaligned;
   assign w_offset   = addr_i - BASE_ADDR;
   assign w_idx      = c_idx_w'(w_offset >> c_offs_w);
   assign w_rd_word  = r_mem[w_idx];

   // ------------------------------------------------------------------
   // Grant
   // ------------------------------------------------------------------
   logic w_rvalid;
   logic w_slot_free;
   logic w_stall_done;
   logic w_gnt;

   // A response retiring this cycle hands its slot straight to a new grant,
   // which is what allows one grant per cycle at full occupancy.
   assign w_slot_free  = (r_outstanding < c_max_out) | w_rvalid;
   assign w_stall_done = (r_stall_cnt == c_stall_max);
   // rst_ni is part of the term so the grant drops as soon as reset asserts.
   assign w_gnt        = req_i & w_stall_done & w_slot_free & ~load_en_i & rst_ni;
   assign gnt_o        = w_gnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
      end else if (!req_i || w_gnt) begin
         r_stall_cnt <= '0;
      end else if (!w_stall_done) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_outstanding <= '0;
      end else begin
         case ({w_gnt, w_rvalid})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Array: contents survive reset. A load blocks grants in its cycle,
   // so the load and bus-write branches never both fire.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (load_en_i) begin
         if (32'(load_idx_i) < DEPTH_WORDS) begin
            r_mem[load_idx_i] <= load_data_i;
         end
      end else if (w_gnt && we_i && !w_dec_err) begin
         for (int b = 0; b < c_be_w; b++) begin
            if (be_i[b]) begin
               r_mem[w_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response
   // ------------------------------------------------------------------
   logic                  w_resp_err;
   logic [DATA_WIDTH-1:0] w_resp_data;
   logic [DATA_WIDTH:0]   w_pipe_out;

   // The read word is taken before this edge's write lands, but a read
   // and a write to the same word cannot share a grant edge, so the read
   // still sees every earlier granted write.
   assign w_resp_err  = w_dec_err;
   assign w_resp_data = (w_dec_err | we_i) ? '0 : w_rd_word;

   zeroriscy_mem_resp_pipe #(
      .STAGES (RVALID_LAT),
      .WIDTH  (DATA_WIDTH + 1)
   ) u_resp_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_valid (w_gnt),
      .i_data  ({w_resp_err, w_resp_data}),
      .o_valid (w_rvalid),
      .o_data  (w_pipe_out)
   );

   assign rvalid_o = w_rvalid;
   assign rdata_o  = w_rvalid ? w_pipe_out[DATA_WIDTH-1:0] : '0;
   assign err_o    = w_rvalid & w_pipe_out[DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_zeroriscy_mem_slave                                       |
// | Description : Bench for zeroriscy_mem_slave. It has three instances:       |
// |               dut0 has no stall and latency 1; dut1 has GNT_STALL=2;       |
// |               dut2 has latency 3 with two outstanding. Expected responses  |
// |               are queued at grant and checked when rvalid appears.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_zeroriscy_mem_slave;

   localparam int NI    = 3;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [NI];
   logic        req       [NI];
   logic        gnt       [NI];
   logic        we        [NI];
   logic [3:0]  be        [NI];
   logic [31:0] addr      [NI];
   logic [31:0] wdata     [NI];
   logic        rvalid    [NI];
   logic [31:0] rdata     [NI];
   logic        err       [NI];
   logic        load_en   [NI];
   logic [3:0]  load_idx  [NI];
   logic [31:0] load_data [NI];

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] model [NI][DEPTH];

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q [NI][$];

   function automatic int lat_of(input int k);
      return (k == 2) ? 3 : 1;
   endfunction

   zeroriscy_mem_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0),
      .GNT_STALL(0), .RVALID_LAT(1), .MAX_OUTSTANDING(1)
   ) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]),
      .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
      .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
      .load_en_i(load_en[0]), .load_idx_i(load_idx[0]), .load_data_i(load_data[0])
   );

   zeroriscy_mem_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0),
      .GNT_STALL(2), .RVALID_LAT(1), .MAX_OUTSTANDING(1)
   ) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]),
      .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
      .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
      .load_en_i(load_en[1]), .load_idx_i(load_idx[1]), .load_data_i(load_data[1])
   );

   zeroriscy_mem_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0),
      .GNT_STALL(0), .RVALID_LAT(3), .MAX_OUTSTANDING(2)
   ) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]),
      .we_i(we[2]), .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]),
      .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
      .load_en_i(load_en[2]), .load_idx_i(load_idx[2]), .load_data_i(load_data[2])
   );

   // Response monitor: every rvalid must match the oldest queued response,
   // including its cycle; an idle response port must read all zeros.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (rvalid[k] === 1'b1) begin
            if (sb_q[k].size() == 0) begin
               errors++;
               $display("FAIL rvalid_unexpected dut%0d: got rvalid=1 rdata=%h at cycle %0d, expected no response",
                        k, rdata[k], cyc);
            end else begin
               e = sb_q[k].pop_front();
               if (rdata[k] !== e.data || err[k] !== e.err || cyc !== e.cyc) begin
                  errors++;
                  $display("FAIL response dut%0d: got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                           k, rdata[k], err[k], cyc, e.data, e.err, e.cyc);
               end
            end
         end else if (rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
            errors++;
            $display("FAIL idle_response dut%0d: got rvalid=%b rdata=%h err=%b, expected 0/0/0 at cycle %0d",
                     k, rvalid[k], rdata[k], err[k], cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int k, input logic [3:0] idx, input logic [31:0] d);
      load_en[k]   = 1'b1;
      load_idx[k]  = idx;
      load_data[k] = d;
      step();
      load_en[k]   = 1'b0;
      model[k][idx] = d;
   endtask

   // Drives one request and waits for its grant. The expected response is
   // queued at the grant, and the model is updated for writes.
   task automatic issue(input int k, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output int gcyc);
      exp_t e;
      bit   granted;
      granted  = 1'b0;
      gcyc     = -1;
      req[k]   = 1'b1;
      we[k]    = w;
      be[k]    = b;
      addr[k]  = a;
      wdata[k] = d;
      for (int i = 0; i < 20 && !granted; i++) begin
         @(negedge clk);
         if (gnt[k] === 1'b1) begin
            granted = 1'b1;
            gcyc    = cyc;
            e.cyc   = cyc + lat_of(k);
            e.err   = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
            e.data  = (e.err || w) ? 32'h0 : model[k][a[5:2]];
            if (w && !e.err) begin
               for (int j = 0; j < 4; j++) begin
                  if (b[j]) model[k][a[5:2]][j*8 +: 8] = d[j*8 +: 8];
               end
            end
            sb_q[k].push_back(e);
         end
      end
      if (!granted) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout dut%0d: got no gnt within 20 cycles for addr %h, expected a grant", k, a);
         req[k] = 1'b0;
      end else begin
         step();
         if (!hold) req[k] = 1'b0;
      end
   endtask

   task automatic test_reset();
      req[0]  = 1'b1;
      addr[0] = 32'h0;
      step();
      step();
      for (int k = 0; k < NI; k++) begin
         checks += 4;
         if (gnt[k] !== 1'b0) begin
            errors++; $display("FAIL reset_gnt dut%0d: got %b, expected 0", k, gnt[k]);
         end
         if (rvalid[k] !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid dut%0d: got %b, expected 0", k, rvalid[k]);
         end
         if (rdata[k] !== 32'h0) begin
            errors++; $display("FAIL reset_rdata dut%0d: got %h, expected 0", k, rdata[k]);
         end
         if (err[k] !== 1'b0) begin
            errors++; $display("FAIL reset_err dut%0d: got %b, expected 0", k, err[k]);
         end
      end
      req[0] = 1'b0;
      for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
      step();
   endtask

   task automatic test_read_preload();
      int start, g;
      load(0, 4'd0, 32'h00300293);
      start = cyc;
      issue(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, g);
      checks++;
      if (g !== start) begin
         errors++; $display("FAIL read_gnt_cycle: got grant in cycle %0d, expected %0d", g, start);
      end
      step();
      step();
   endtask

   task automatic test_byte_write();
      int g1, g2;
      load(0, 4'd1, 32'h11223344);
      issue(0, 1'b1, 4'b0101, 32'h4, 32'hAABBCCDD, 1'b1, g1);
      issue(0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, g2);
      checks++;
      if (g2 !== g1 + 1) begin
         errors++; $display("FAIL b2b_single_slot: got read grant in cycle %0d, expected %0d", g2, g1 + 1);
      end
      checks++;
      if (model[0][1] !== 32'h11BB33DD) begin
         errors++; $display("FAIL byte_merge_model: got %h, expected 11bb33dd", model[0][1]);
      end
      step();
      step();
   endtask

   task automatic test_errors();
      logic [31:0] rd_addrs [3];
      logic [31:0] wr_addrs [2];
      int g;
      rd_addrs = '{32'h2, 32'(DEPTH * 4), 32'hFFFF_FFFC};
      wr_addrs = '{32'(DEPTH * 4), 32'h6};
      foreach (rd_addrs[i]) issue(0, 1'b0, 4'hF, rd_addrs[i], 32'h0, 1'b0, g);
      foreach (wr_addrs[i]) issue(0, 1'b1, 4'hF, wr_addrs[i], 32'hFFFF_FFFF, 1'b0, g);
      // Out-of-range and misaligned writes alias words 0 and 1 if not blocked.
      issue(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, g);
      issue(0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, g);
      step();
      step();
   endtask

   task automatic test_load_block();
      int start, g;
      req[0]       = 1'b1;
      we[0]        = 1'b0;
      be[0]        = 4'hF;
      addr[0]      = 32'h8;
      load_en[0]   = 1'b1;
      load_idx[0]  = 4'd2;
      load_data[0] = 32'h5A5A0F0F;
      @(negedge clk);
      checks++;
      if (gnt[0] !== 1'b0) begin
         errors++; $display("FAIL load_blocks_gnt: got gnt=%b during load, expected 0", gnt[0]);
      end
      step();
      load_en[0]  = 1'b0;
      model[0][2] = 32'h5A5A0F0F;
      start = cyc;
      issue(0, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, g);
      checks++;
      if (g !== start) begin
         errors++; $display("FAIL gnt_after_load: got grant in cycle %0d, expected %0d", g, start);
      end
      step();
      step();
   endtask

   task automatic stall_window(input int n, input int grant_at);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (gnt[1] !== ((i == grant_at) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL stall_gnt: got gnt=%b in request cycle %0d, expected %b",
                     gnt[1], i, (i == grant_at));
         end
         if (gnt[1] === 1'b1) begin
            e.cyc  = cyc + 1;
            e.err  = 1'b0;
            e.data = model[1][0];
            sb_q[1].push_back(e);
         end
         step();
      end
   endtask

   task automatic test_stall();
      load(1, 4'd0, 32'hCAFEF00D);
      we[1]   = 1'b0;
      be[1]   = 4'hF;
      addr[1] = 32'h0;
      req[1]  = 1'b1;
      stall_window(3, 2);
      req[1]  = 1'b0;
      step();
      // Request dropped before its grant: no transaction, counter restarts.
      req[1]  = 1'b1;
      stall_window(2, -1);
      req[1]  = 1'b0;
      stall_window(1, -1);
      req[1]  = 1'b1;
      stall_window(3, 2);
      req[1]  = 1'b0;
      step();
      step();
   endtask

   task automatic test_back_to_back();
      int g [4];
      int exp_off [4];
      int start;
      exp_off = '{0, 1, 3, 4};
      for (int i = 0; i < 4; i++) load(2, 4'(i), 32'h1000_0000 + 32'(i) * 32'h0111_0111);
      start = cyc;
      for (int i = 0; i < 4; i++) issue(2, 1'b0, 4'hF, 32'(i * 4), 32'h0, 1'b1, g[i]);
      req[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (g[i] - start !== exp_off[i]) begin
            errors++;
            $display("FAIL b2b_grant%0d: got grant at offset %0d, expected %0d", i, g[i] - start, exp_off[i]);
         end
      end
      repeat (6) step();
   endtask

   task automatic test_reset_mid();
      int g0, g1, ga, gb, start;
      issue(2, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, g0);
      issue(2, 1'b0, 4'hF, 32'h4, 32'h0, 1'b1, g1);
      step();
      checks++;
      if (rvalid[2] !== 1'b1) begin
         errors++; $display("FAIL inflight_rvalid: got %b before reset, expected 1", rvalid[2]);
      end
      rst_n[2] = 1'b0;
      #1;
      checks += 3;
      if (rvalid[2] !== 1'b0) begin
         errors++; $display("FAIL midreset_rvalid: got %b, expected 0", rvalid[2]);
      end
      if (gnt[2] !== 1'b0) begin
         errors++; $display("FAIL midreset_gnt: got %b, expected 0", gnt[2]);
      end
      if (rdata[2] !== 32'h0) begin
         errors++; $display("FAIL midreset_rdata: got %h, expected 0", rdata[2]);
      end
      sb_q[2].delete();
      req[2] = 1'b0;
      step();
      step();
      rst_n[2] = 1'b1;
      repeat (8) step();
      start = cyc;
      issue(2, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, ga);
      issue(2, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, gb);
      checks += 2;
      if (ga !== start) begin
         errors++; $display("FAIL post_reset_gnt0: got grant in cycle %0d, expected %0d", ga, start);
      end
      if (gb !== start + 1) begin
         errors++; $display("FAIL post_reset_gnt1: got grant in cycle %0d, expected %0d", gb, start + 1);
      end
      repeat (6) step();
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_n[k]     = 1'b0;
         req[k]       = 1'b0;
         we[k]        = 1'b0;
         be[k]        = 4'h0;
         addr[k]      = 32'h0;
         wdata[k]     = 32'h0;
         load_en[k]   = 1'b0;
         load_idx[k]  = 4'h0;
         load_data[k] = 32'h0;
      end
      #1;
      test_reset();
      test_read_preload();
      test_byte_write();
      test_errors();
      test_load_block();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (sb_q[k].size() != 0) begin
            errors++;
            $display("FAIL pending_responses dut%0d: got %0d unanswered, expected 0", k, sb_q[k].size());
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
